// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } clkdiv_state_t;

  // Width of one divisor / high-time field able to hold 0..div_max.
  function automatic int clkdiv_dw(input int div_max);
    return $clog2(div_max + 1);
  endfunction

endpackage

// File: rtl/clkdiv_ch.sv
// One divider channel: shadowed divisor/high time, IDLE/RUN/STOP FSM,
// period counter and registered clk_div / stb outputs.
module clkdiv_ch
  import clkdiv_pkg::*;
#(
  parameter int DW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          load,
  input  logic          sync,
  input  logic [DW-1:0] div,
  input  logic [DW-1:0] hi,
  output logic          clk_div,
  output logic          stb,
  output logic          busy,
  output logic          pend
);

  clkdiv_state_t state, state_nx;
  logic [DW-1:0] cnt, cnt_nx;
  logic [DW-1:0] div_a, hi_a, div_s, hi_s;
  logic [DW-1:0] div_a_nx, hi_a_nx, eff_div;
  logic          pend_q, apply, period_end, restart;
  logic          clk_div_nx, stb_nx;

  assign eff_div    = pend_q ? div_s : div_a;
  assign period_end = (cnt == div_a - DW'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_a   <= '0;
      hi_a    <= '0;
      div_s   <= '0;
      hi_s    <= '0;
      pend_q  <= 1'b0;
      clk_div <= 1'b0;
      stb     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      div_a   <= div_a_nx;
      hi_a    <= hi_a_nx;
      if (load) begin
        div_s <= div;
        hi_s  <= hi;
      end
      // A load in the same cycle as an apply re-arms the flag for the new values.
      pend_q  <= load | (pend_q & ~apply);
      clk_div <= clk_div_nx;
      stb     <= stb_nx;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    apply    = 1'b0;
    restart  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (en && eff_div != '0) begin
          state_nx = RUN;
          apply    = pend_q;
        end
      end
      RUN, STOP: begin
        // sync only restarts running channels; a stopping one finishes its period.
        restart = period_end || (sync && state == RUN);
        if (restart) begin
          cnt_nx = '0;
          apply  = pend_q;
        end else begin
          cnt_nx = cnt + DW'(1);
        end
        if (!en) state_nx = restart ? IDLE : STOP;
        else     state_nx = RUN;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase

    div_a_nx = apply ? div_s : div_a;
    hi_a_nx  = apply ? hi_s  : hi_a;

    // A zero divisor arriving at a boundary parks the channel.
    if (state_nx != IDLE && div_a_nx == '0) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  // Outputs are computed from next-state values so a channel leaving RUN
  // never emits a one-cycle runt high.
  always_comb begin
    clk_div_nx = (state_nx != IDLE) && (cnt_nx < hi_a_nx);
    stb_nx     = (state_nx != IDLE) && (cnt_nx == '0);
  end

  assign busy = (state != IDLE);
  assign pend = pend_q;

endmodule

// File: rtl/clkdiv_mc.sv
// Multi-channel programmable clock divider: NCH independent channels
// sharing only clk, rst and the phase-align sync input.
module clkdiv_mc
  import clkdiv_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int DIV_MAX = 256,
  localparam int DW      = clkdiv_dw(DIV_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  en,
  input  logic [NCH-1:0]  load,
  input  logic [NCH*DW-1:0] div,
  input  logic [NCH*DW-1:0] hi,
  input  logic            sync,
  output logic [NCH-1:0]  clk_div,
  output logic [NCH-1:0]  stb,
  output logic [NCH-1:0]  busy,
  output logic [NCH-1:0]  pend
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    clkdiv_ch #(
      .DW(DW)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[c]),
      .load    (load[c]),
      .sync    (sync),
      .div     (div[c*DW +: DW]),
      .hi      (hi[c*DW +: DW]),
      .clk_div (clk_div[c]),
      .stb     (stb[c]),
      .busy    (busy[c]),
      .pend    (pend[c])
    );
  end

endmodule

// File: tb/tb_clkdiv_mc.sv
// Scoreboard bench for clkdiv_mc: expected per-channel outputs are queued
// as stimulus is driven and drained one clock later.
module tb_clkdiv_mc;
  import clkdiv_pkg::*;

  localparam int NCH     = 4;
  localparam int DIV_MAX = 256;
  localparam int DW      = clkdiv_dw(DIV_MAX);

  logic              clk  = 1'b0;
  logic              rst  = 1'b1;
  logic [NCH-1:0]    en   = '0;
  logic [NCH-1:0]    load = '0;
  logic [NCH*DW-1:0] div  = '0;
  logic [NCH*DW-1:0] hi   = '0;
  logic              sync = 1'b0;
  logic [NCH-1:0]    clk_div, stb, busy, pend;

  typedef struct {
    int         ch;
    logic [3:0] cdbp;
    string      tag;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  clkdiv_mc #(
    .NCH     (NCH),
    .DIV_MAX (DIV_MAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .load    (load),
    .div     (div),
    .hi      (hi),
    .sync    (sync),
    .clk_div (clk_div),
    .stb     (stb),
    .busy    (busy),
    .pend    (pend)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int d, input int h);
    div[ch*DW +: DW] = DW'(d);
    hi[ch*DW +: DW]  = DW'(h);
  endtask

  task automatic push(input int ch, input logic c, input logic s, input logic b,
                      input logic p, input string tag, input int cyc);
    exp_t e;
    e.ch   = ch;
    e.cdbp = {c, s, b, p};
    e.tag  = tag;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  // Advance one clock, then retire every expectation queued for it.
  task automatic score();
    exp_t       e;
    logic [3:0] got;
    cycle();
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {clk_div[e.ch], stb[e.ch], busy[e.ch], pend[e.ch]};
      n_checks++;
      if (got !== e.cdbp) begin
        n_fail++;
        $display("FAIL %s ch%0d k=%0d: clk_div/stb/busy/pend got %b want %b",
                 e.tag, e.ch, e.cyc, got, e.cdbp);
      end
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = '0;
    load = '0;
    sync = 1'b0;
    cycle();
    rst  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (clk_div !== '0) begin n_fail++; $display("FAIL reset_clk_div got %b want 0", clk_div); end
    n_checks++;
    if (stb !== '0) begin n_fail++; $display("FAIL reset_stb got %b want 0", stb); end
    n_checks++;
    if (busy !== '0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++;
    if (pend !== '0) begin n_fail++; $display("FAIL reset_pend got %b want 0", pend); end
  endtask

  task automatic test_basic();
    do_reset();
    cfg(0, 4, 2);
    load[0] = 1'b1;
    en[0]   = 1'b1;
    push(0, 1'b0, 1'b0, 1'b0, 1'b1, "basic_load", -1);
    score();
    load[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      push(0, (k % 4) < 2, (k % 4) == 0, 1'b1, 1'b0, "basic_1100", k);
      score();
    end
  endtask

  task automatic test_shadow();
    do_reset();
    cfg(1, 5, 2);
    load[1] = 1'b1;
    en[1]   = 1'b1;
    push(1, 1'b0, 1'b0, 1'b0, 1'b1, "shadow_load", -1);
    score();
    load[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k == 7) begin
        cfg(1, 3, 1);
        load[1] = 1'b1;
      end
      if (k < 10)
        push(1, (k % 5) < 2, (k % 5) == 0, 1'b1, (k >= 7), "shadow_div5", k);
      else
        push(1, ((k - 10) % 3) < 1, ((k - 10) % 3) == 0, 1'b1, 1'b0, "shadow_div3", k);
      score();
      load[1] = 1'b0;
    end
  endtask

  task automatic test_stop(input logic resume);
    do_reset();
    cfg(0, 4, 2);
    load[0] = 1'b1;
    en[0]   = 1'b1;
    push(0, 1'b0, 1'b0, 1'b0, 1'b1, "stop_load", -1);
    score();
    load[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      en[0] = resume ? (k != 6) : (k < 6);
      if (resume || k < 8)
        push(0, (k % 4) < 2, (k % 4) == 0, 1'b1, 1'b0, resume ? "stop_resume" : "stop_drain", k);
      else
        push(0, 1'b0, 1'b0, 1'b0, 1'b0, "stop_idle", k);
      score();
    end
  endtask

  task automatic test_sync();
    int c0, c2;
    do_reset();
    cfg(0, 6, 3);
    cfg(2, 3, 1);
    load[0] = 1'b1;
    load[2] = 1'b1;
    en[0]   = 1'b1;
    push(0, 1'b0, 1'b0, 1'b0, 1'b1, "sync_load", -1);
    push(2, 1'b0, 1'b0, 1'b0, 1'b1, "sync_load", -1);
    score();
    load = '0;
    push(0, 1'b1, 1'b1, 1'b1, 1'b0, "sync_start", 0);
    push(2, 1'b0, 1'b0, 1'b0, 1'b1, "sync_wait", 0);
    score();
    en[2] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      sync = (k == 8);
      if (k < 8) begin
        c0 = k % 6;
        c2 = (k - 1) % 3;
      end else begin
        c0 = (k - 8) % 6;
        c2 = (k - 8) % 3;
      end
      push(0, c0 < 3, c0 == 0, 1'b1, 1'b0, "sync_ch0", k);
      push(2, c2 < 1, c2 == 0, 1'b1, 1'b0, "sync_ch2", k);
      score();
    end
    sync = 1'b0;
  endtask

  task automatic test_edges();
    do_reset();
    cfg(0, 4, 0);
    cfg(1, 4, 7);
    cfg(2, 1, 1);
    cfg(3, 1, 0);
    load = '1;
    en   = '1;
    for (int c = 0; c < NCH; c++) push(c, 1'b0, 1'b0, 1'b0, 1'b1, "edge_load", -1);
    score();
    load = '0;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        cfg(1, 0, 7);
        load[1] = 1'b1;
      end
      push(0, 1'b0, (k % 4) == 0, 1'b1, 1'b0, "edge_hi0", k);
      if (k < 8)
        push(1, 1'b1, (k % 4) == 0, 1'b1, (k >= 5), "edge_hi7", k);
      else
        push(1, 1'b0, 1'b0, 1'b0, 1'b0, "edge_div0", k);
      push(2, 1'b1, 1'b1, 1'b1, 1'b0, "edge_div1_hi1", k);
      push(3, 1'b0, 1'b1, 1'b1, 1'b0, "edge_div1_hi0", k);
      score();
      load[1] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < NCH; c++) cfg(c, 5, 2);
    load = '1;
    en   = '1;
    cycle();
    load = '0;
    repeat (3) cycle();
    for (int c = 0; c < NCH; c++) cfg(c, 3, 1);
    load = '1;
    cycle();
    load = '0;
    n_checks++;
    if (pend !== '1) begin n_fail++; $display("FAIL mid_pend_set got %b want 1111", pend); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_checks++;
    if ({clk_div, stb, busy, pend} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset clk_div/stb/busy/pend got %b want 0", {clk_div, stb, busy, pend});
    end
    repeat (2) cycle();
    n_checks++;
    if ({clk_div, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_stay_idle clk_div/busy got %b want 0", {clk_div, busy});
    end
    load = '1;
    cycle();
    load = '0;
    n_checks++;
    if ({busy, pend} !== {4'b0000, 4'b1111}) begin
      n_fail++;
      $display("FAIL mid_reload busy/pend got %b want 00001111", {busy, pend});
    end
    cycle();
    n_checks++;
    if ({clk_div, stb, busy, pend} !== {4'b1111, 4'b1111, 4'b1111, 4'b0000}) begin
      n_fail++;
      $display("FAIL mid_restart clk_div/stb/busy/pend got %b want 1111111111110000",
               {clk_div, stb, busy, pend});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shadow();
    test_stop(1'b0);
    test_stop(1'b1);
    test_sync();
    test_edges();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
